// File: rtl/issue_sched_if.sv
`default_nettype none
// ============================================================================
// issue_sched_if : IFetch/Decoder/ROB handshake bundle for the issue scheduler
// Rev 1.0
// ============================================================================
interface issue_sched_if #(
  parameter int ROB_POS_W   = 4,
  parameter int STALL_CNT_W = 16
);
  logic                   rdy;
  logic                   rollback;
  logic                   inst_rdy;
  logic [6:0]             inst_opcode;
  logic                   rs_nxt_full;
  logic                   lsb_nxt_full;
  logic                   commit;
  logic                   issue_grant;
  logic                   inst_ack;
  logic [ROB_POS_W-1:0]   nxt_rob_pos;
  logic [ROB_POS_W-1:0]   rob_head;
  logic                   rob_full;
  logic                   rob_empty;
  logic                   flushing;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output rdy, rollback, inst_rdy, inst_opcode, rs_nxt_full, lsb_nxt_full, commit,
    input  issue_grant, inst_ack, nxt_rob_pos, rob_head, rob_full, rob_empty,
           flushing, stall_cnt
  );

  modport slave (
    input  rdy, rollback, inst_rdy, inst_opcode, rs_nxt_full, lsb_nxt_full, commit,
    output issue_grant, inst_ack, nxt_rob_pos, rob_head, rob_full, rob_empty,
           flushing, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/issue_sched.sv
`default_nettype none
// ============================================================================
// issue_sched : issue-stage scheduler owning ROB allocation, flush gating and
//               stall statistics
// Rev 1.0
// ============================================================================
module issue_sched #(
  parameter int ROB_POS_W    = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  issue_sched_if.slave bus
);

  localparam int                 DEPTH      = 2 ** ROB_POS_W;
  localparam logic [ROB_POS_W:0] DEPTH_CNT  = (ROB_POS_W + 1)'(DEPTH);
  localparam logic [2:0]         FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                 state;
  logic [2:0]             timer;
  logic [ROB_POS_W-1:0]   head;
  logic [ROB_POS_W-1:0]   tail;
  logic [ROB_POS_W:0]     count;
  logic [STALL_CNT_W-1:0] stall_cnt;

  logic is_lsb;
  logic is_rs;
  logic full;
  logic active;
  logic stall;
  logic grant;
  logic commit_ok;

  always_comb begin
    is_lsb = 1'b0;
    is_rs  = 1'b0;
    case (bus.inst_opcode)
      7'b0000011, 7'b0100011: is_lsb = 1'b1;
      7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111: is_rs = 1'b1;
      default: ;
    endcase
  end

  // Full uses the registered count only, so a same-cycle commit never
  // unblocks issue until the following cycle.
  assign full      = (count == DEPTH_CNT);
  assign active    = rst && (state == RUN) && bus.rdy && !bus.rollback && bus.inst_rdy;
  assign stall     = active && ((is_lsb && (bus.lsb_nxt_full || full)) ||
                                (is_rs  && (bus.rs_nxt_full  || full)));
  assign grant     = active && (is_lsb || is_rs) && !stall;
  assign commit_ok = bus.commit && (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      timer     <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else if (bus.rdy) begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (bus.rollback) begin
        state <= FLUSH;
        timer <= FLUSH_LOAD;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (state == FLUSH) begin
          if (timer == '0) begin
            state <= RUN;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        if (grant) begin
          tail <= tail + 1'b1;
        end
        if (commit_ok) begin
          head <= head + 1'b1;
        end
        if (grant && !commit_ok) begin
          count <= count + 1'b1;
        end else if (!grant && commit_ok) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  // Illegal opcodes are acknowledged so IFetch can drop them.
  assign bus.issue_grant = grant;
  assign bus.inst_ack    = grant || (active && !is_lsb && !is_rs);
  assign bus.nxt_rob_pos = tail;
  assign bus.rob_head    = head;
  assign bus.rob_full    = full;
  assign bus.rob_empty   = (count == '0);
  assign bus.flushing    = (state == FLUSH);
  assign bus.stall_cnt   = stall_cnt;

endmodule
`default_nettype wire
